// File: rtl/reg_dump_reader.sv
// Register-file dump reader: walks every register through a dedicated read
// port and streams {index, data} words out on a valid/ready interface.
module reg_dump_reader #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        SEND,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                // abort in IDLE masks start
                if (start && !abort) begin
                    state_d = SEL;
                    ptr_d   = '0;
                end
            end
            SEL: begin
                if (abort) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    idx_d   = ptr_q;
                    data_d  = reg_data;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (out_ready) begin
                    if (ptr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + SEL_W'(1);
                        state_d = SEL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign reg_sel   = ptr_q;
    assign out_valid = (state_q == SEND);
    assign out_index = idx_q;
    assign out_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a register-file model feeds the read
// port, expected words are queued at stimulus time and popped by a monitor.
module tb_reg_dump_reader;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [2:0]  reg_sel;
    logic [15:0] reg_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_index;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    logic [15:0] rf [0:7];
    logic [18:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int mode     = 0;
    int stall_left = 0;
    bit wrote    = 0;

    reg_dump_reader #(.NUM_REGS(8), .SEL_W(3), .DATA_W(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    assign reg_data = rf[reg_sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Consumer model: ready policy plus timed register-file writes.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (out_valid && out_index == 3'd4 && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
            3: begin
                out_ready = 1'b1;
                if (out_valid && out_index == 3'd2 && !wrote) begin
                    rf[6] = 16'hBEEF;
                    rf[1] = 16'hDEAD;
                    wrote = 1'b1;
                end
            end
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on each handshake and checks hold stability.
    bit          held = 0;
    logic [2:0]  h_idx;
    logic [15:0] h_data;
    always @(negedge clk) begin
        if (resetn && done) done_cnt++;
        if (resetn && out_valid) begin
            if (held) begin
                check("hold_index", 32'(out_index), 32'(h_idx));
                check("hold_data", 32'(out_data), 32'(h_data));
            end
            if (out_ready && !abort) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %0h:%0h expected none",
                             out_index, out_data);
                end else begin
                    logic [18:0] w;
                    w = exp_q.pop_front();
                    check("word_index", 32'(out_index), 32'(w[18:16]));
                    check("word_data", 32'(out_data), 32'(w[15:0]));
                end
            end else begin
                held   = !abort;
                h_idx  = out_index;
                h_data = out_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic push_all();
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), rf[i]});
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    endtask

    // One full dump launched after an edge; exp_cyc < 0 skips the timing check.
    task automatic do_dump(input bit spam, input int exp_cyc, input bit chk_first);
        int n;
        int d0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        check("idle_before_start", 32'(busy), 32'd0);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            start = spam;
            if (chk_first && n == 1) check("valid_edge1", 32'(out_valid), 32'd0);
            if (chk_first && n == 1) check("busy_edge1", 32'(busy), 32'd1);
            if (chk_first && n == 2) check("valid_edge2", 32'(out_valid), 32'd1);
            if (chk_first && n == 2) check("index_edge2", 32'(out_index), 32'd0);
        end while (!done && n < 400);
        check("done_seen", 32'(done), 32'd1);
        if (exp_cyc >= 0) check("done_latency", 32'(n), 32'(exp_cyc));
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        start = 1'b0;
        check("done_count", 32'(done_cnt), 32'(d0 + 1));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        resetn    = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        preload();
        #3 resetn = 1'b0;
        #4;
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #15 resetn = 1'b1;

        // straight dump, ready held high
        mode = 0;
        push_all();
        do_dump(0, 17, 1);
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);

        // 3-cycle stall on word 4
        mode = 2;
        stall_left = 3;
        push_all();
        do_dump(0, 20, 0);

        // writes during the dump: r6 not yet captured, r1 already emitted
        mode = 3;
        wrote = 0;
        for (int i = 0; i < 8; i++)
            exp_q.push_back({3'(i), (i == 6) ? 16'hBEEF : 16'h1000 + 16'(i)});
        do_dump(0, 17, 0);
        preload();

        // abort during SEND of word 3 with ready high
        mode = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back({3'(i), rf[i]});
        d0 = done_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!(out_valid && out_index == 3'd3) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reached_word3", 32'(out_valid && out_index == 3'd3), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_reg_sel", 32'(reg_sel), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done_pulse", 32'(done_cnt), 32'(d0));
        check("abort_stays_idle", 32'(busy), 32'd0);
        push_all();
        do_dump(0, 17, 1);

        // asynchronous reset during SEL of word 3
        push_all();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!(busy && !out_valid && out_index == 3'd2) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reset_reached_sel", 32'(busy && !out_valid && out_index == 3'd2), 32'd1);
        d0 = done_cnt;
        #2 resetn = 1'b0;
        #1;
        check("arst_reg_sel", 32'(reg_sel), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_index", 32'(out_index), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        exp_q.delete();
        #12 resetn = 1'b1;
        check("arst_no_done_pulse", 32'(done_cnt), 32'(d0));
        push_all();
        do_dump(0, 17, 1);

        // start held through the dump and its DONE cycle, then restart at once
        push_all();
        do_dump(1, 17, 0);
        push_all();
        do_dump(0, 17, 1);

        // randomized data and back-pressure
        mode = 1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            push_all();
            do_dump(0, -1, 0);
        end
        mode = 0;

        repeat (2) @(posedge clk);
        #1;
        check("total_done_pulses", 32'(done_cnt), 32'd11);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
